// File: rtl/neuron_lut_pkg.sv
// Shared types and sizing helpers for the reloadable LogicNets neuron.
// The package defaults describe a 4-input, 2-bit neuron.
`timescale 1ns/1ps
package neuron_lut_pkg;

  localparam int DEF_FAN_IN   = 4;
  localparam int DEF_IN_BITS  = 2;
  localparam int DEF_OUT_BITS = 2;

  typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;

  typedef logic [DEF_OUT_BITS-1:0] entry_t;

  function automatic int lut_addr_w(input int fan_in, input int in_bits);
    return fan_in * in_bits;
  endfunction

  function automatic int lut_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/neuron_lut_stream_if.sv
// Configuration and streaming signals of one neuron instance.
// The slave modport is the neuron's view; the master modport is the neighbour/driver view.
`timescale 1ns/1ps
interface neuron_lut_stream_if
  import neuron_lut_pkg::*;
#(
  parameter int FAN_IN   = DEF_FAN_IN,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
);

  localparam int ADDR_W = lut_addr_w(FAN_IN, IN_BITS);

  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                loaded;
  logic                s_valid;
  logic                s_ready;
  logic [ADDR_W-1:0]   s_data;
  logic                m_valid;
  logic                m_ready;
  logic [OUT_BITS-1:0] m_data;

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, s_valid, s_data, m_ready,
    output cfg_ready, loaded, s_ready, m_valid, m_data
  );

  modport master (
    output cfg_start, cfg_valid, cfg_data, s_valid, s_data, m_ready,
    input  cfg_ready, loaded, s_ready, m_valid, m_data
  );

endinterface

// File: rtl/neuron_lut_ram.sv
// Truth-table storage: one synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the table is always reloaded before use.
`timescale 1ns/1ps
module neuron_lut_ram
  import neuron_lut_pkg::*;
#(
  parameter int ADDR_W = lut_addr_w(DEF_FAN_IN, DEF_IN_BITS),
  parameter int DATA_W = DEF_OUT_BITS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = lut_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/neuron_lut_stream.sv
// Reloadable LUT neuron: serial table load FSM plus a 2-stage valid/ready lookup pipeline.
// Table writes only happen in LOAD, where the pipeline is guaranteed empty.
`timescale 1ns/1ps
module neuron_lut_stream
  import neuron_lut_pkg::*;
#(
  parameter int FAN_IN   = DEF_FAN_IN,
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS
) (
  input logic               clk,
  input logic               rst_n,
  neuron_lut_stream_if.slave bus
);

  localparam int ADDR_W = lut_addr_w(FAN_IN, IN_BITS);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic                cfg_beat;
  logic                last_beat;
  logic                en;
  logic                drained;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic                m_valid_q;
  logic [OUT_BITS-1:0] m_data_q;
  logic [OUT_BITS-1:0] rd_data;
  logic                cfg_ready_c;
  logic                s_ready_c;
  logic                loaded_c;

  // A beat coinciding with cfg_start is dropped so the restart begins cleanly at 0.
  assign en        = !m_valid_q || bus.m_ready;
  assign cfg_beat  = (state == LOAD) && bus.cfg_valid && !bus.cfg_start;
  assign last_beat = cfg_beat && (&cnt);
  assign drained   = !s1_valid && !m_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (bus.cfg_start) state_nxt = LOAD;
      LOAD:    if (last_beat)     state_nxt = RUN;
      RUN:     if (bus.cfg_start) state_nxt = DRAIN;
      DRAIN:   if (drained)       state_nxt = LOAD;
      default:                    state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    cfg_ready_c = 1'b0;
    s_ready_c   = 1'b0;
    loaded_c    = 1'b0;
    case (state)
      LOAD: cfg_ready_c = 1'b1;
      RUN: begin
        loaded_c  = 1'b1;
        s_ready_c = en;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (state != LOAD || bus.cfg_start)   cnt <= '0;
    else if (cfg_beat)                         cnt <= cnt + 1'b1;
  end

  // Both stages share one enable, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (en) begin
      s1_valid  <= bus.s_valid && s_ready_c;
      s1_addr   <= bus.s_data;
      m_valid_q <= s1_valid;
      if (s1_valid) m_data_q <= rd_data;
    end
  end

  neuron_lut_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (cfg_beat),
    .waddr (cnt),
    .wdata (bus.cfg_data),
    .raddr (s1_addr),
    .rdata (rd_data)
  );

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.s_ready   = s_ready_c;
  assign bus.loaded    = loaded_c;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;

endmodule

// File: tb/tb_neuron_lut_stream.sv
// Self-checking bench for neuron_lut_stream: load, stream, backpressure, drain/reload, restart, reset.
// Expected outputs come from a table model indexed directly by the input vector.
`timescale 1ns/1ps
module tb_neuron_lut_stream;
  import neuron_lut_pkg::*;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  entry_t model [DEPTH];

  neuron_lut_stream_if bus ();

  neuron_lut_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive_idle();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.m_ready   = 1'b0;
  endtask

  task automatic fill_xor_model();
    for (int a = 0; a < DEPTH; a++) begin
      logic [7:0] a8;
      a8 = 8'(a);
      model[a] = a8[1:0] ^ a8[7:6];
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.loaded, bus.cfg_ready, bus.s_ready, bus.m_valid, bus.m_data} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 000000",
               {bus.loaded, bus.cfg_ready, bus.s_ready, bus.m_valid, bus.m_data});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cfg_ready, bus.loaded} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL empty_ignores_cfg: got %b expected 00", {bus.cfg_ready, bus.loaded});
    end
    bus.cfg_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    fill_xor_model();
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = model[a];
      @(negedge clk);
      if (a == 0) begin
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL load_cfg_ready: got %b expected 1", bus.cfg_ready);
        end
      end
      if (a == DEPTH - 1) begin
        checks++;
        if (bus.loaded !== 1'b0) begin
          errors++;
          $display("[TB] FAIL loaded_early: got %b expected 0", bus.loaded);
        end
      end
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.loaded, bus.s_ready, bus.cfg_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL load_done: got %b expected 110", {bus.loaded, bus.s_ready, bus.cfg_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int got = 0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 259; c++) begin
      bus.s_valid = (c < DEPTH);
      bus.s_data  = 8'(c);
      @(negedge clk);
      if (c < DEPTH) begin
        checks++;
        if (bus.s_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_s_ready cycle %0d: got %b expected 1", c, bus.s_ready);
        end
      end
      checks++;
      if (bus.m_valid !== ((c >= 2) && (c < DEPTH + 2))) begin
        errors++;
        $display("[TB] FAIL b2b_m_valid cycle %0d: got %b expected %b", c, bus.m_valid,
                 ((c >= 2) && (c < DEPTH + 2)));
      end
      if (bus.m_valid === 1'b1 && got < DEPTH) begin
        checks++;
        if (bus.m_data !== model[got]) begin
          errors++;
          $display("[TB] FAIL b2b_data addr %0d: got %0h expected %0h", got, bus.m_data, model[got]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (got != DEPTH) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d expected %0d", got, DEPTH);
    end
  endtask

  task automatic test_backpressure();
    entry_t q[$];
    logic   prev_hold = 1'b0;
    entry_t prev_data = '0;
    entry_t exp_d;
    for (int i = 0; i < 500 + 12; i++) begin
      if (i < 500) begin
        bus.s_valid = ($urandom_range(0, 3) != 0);
        bus.s_data  = 8'($urandom);
        bus.m_ready = ($urandom_range(0, 1) == 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
      end
      @(negedge clk);
      if (prev_hold) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL bp_hold: got v=%b d=%0h expected v=1 d=%0h", bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL bp_extra_output: got d=%0h expected no output", bus.m_data);
        end else begin
          exp_d = q.pop_front();
          if (bus.m_data !== exp_d) begin
            errors++;
            $display("[TB] FAIL bp_data: got %0h expected %0h", bus.m_data, exp_d);
          end
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b0 && bus.s_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_accept_stalled: got s_ready=%b expected 0", bus.s_ready);
      end
      if (bus.s_valid && bus.s_ready === 1'b1) q.push_back(model[bus.s_data]);
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_data = bus.m_data;
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_leftover: got %0d pending v=%b expected 0 pending v=0", q.size(), bus.m_valid);
    end
  endtask

  task automatic test_drain_reload();
    logic [7:0] a_addr = 8'($urandom);
    logic [7:0] b_addr = 8'($urandom);
    entry_t q[$];
    entry_t exp_d;
    logic   done = 1'b0;
    int     got = 0;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = a_addr;
    @(posedge clk); #1;
    bus.s_data  = b_addr;
    @(posedge clk); #1;
    bus.s_valid   = 1'b0;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      bus.cfg_start = (k == 2);
      bus.s_valid   = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.cfg_ready, bus.loaded, bus.s_ready, bus.m_valid} !== 4'b0001 || bus.m_data !== model[a_addr]) begin
        errors++;
        $display("[TB] FAIL drain_hold: got rdy/ld/srdy/v=%b d=%0h expected 0001 d=%0h",
                 {bus.cfg_ready, bus.loaded, bus.s_ready, bus.m_valid}, bus.m_data, model[a_addr]);
      end
      @(posedge clk); #1;
    end
    bus.cfg_start = 1'b0;
    bus.s_valid   = 1'b0;
    bus.m_ready   = 1'b1;
    q.push_back(model[a_addr]);
    q.push_back(model[b_addr]);
    for (int k = 0; k < 12 && !done; k++) begin
      @(negedge clk);
      if (bus.cfg_ready === 1'b1) done = 1'b1;
      if (bus.m_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL drain_extra: got d=%0h expected no output", bus.m_data);
        end else begin
          exp_d = q.pop_front();
          if (bus.m_data !== exp_d) begin
            errors++;
            $display("[TB] FAIL drain_data: got %0h expected %0h", bus.m_data, exp_d);
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!done || q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_to_load: got ready=%b pending=%0d expected ready=1 pending=0", done, q.size());
    end
    for (int a = 0; a < DEPTH; a++) model[a] = 2'b11;
    for (int a = 0; a < DEPTH; a++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 2'b11;
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.loaded !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reload_loaded: got %b expected 1", bus.loaded);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 34; i++) begin
      bus.s_valid = (i < 32);
      bus.s_data  = 8'($urandom);
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        checks++;
        got++;
        if (bus.m_data !== model[0]) begin
          errors++;
          $display("[TB] FAIL reload_data: got %0h expected 3", bus.m_data);
        end
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (got != 32) begin
      errors++;
      $display("[TB] FAIL reload_count: got %0d expected 32", got);
    end
  endtask

  task automatic test_restart();
    entry_t newm [DEPTH];
    logic   rdy = 1'b0;
    int     got = 0;
    bus.cfg_start = 1'b1;
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 6 && !rdy; k++) begin
      @(negedge clk);
      rdy = bus.cfg_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_enter_load: got %b expected 1", rdy);
    end
    for (int a = 0; a < 100; a++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 2'($urandom);
      @(posedge clk); #1;
    end
    for (int a = 0; a < DEPTH; a++) newm[a] = 2'($urandom);
    bus.cfg_start = 1'b1;
    bus.cfg_data  = ~newm[1];
    @(posedge clk); #1;
    bus.cfg_start = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      bus.cfg_data = newm[a];
      @(negedge clk);
      if (a == DEPTH - 1) begin
        checks++;
        if (bus.loaded !== 1'b0) begin
          errors++;
          $display("[TB] FAIL restart_loaded_early: got %b expected 0", bus.loaded);
        end
      end
      @(posedge clk); #1;
    end
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.loaded !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_loaded: got %b expected 1", bus.loaded);
    end
    @(posedge clk); #1;
    for (int a = 0; a < DEPTH; a++) model[a] = newm[a];
    bus.m_ready = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      bus.s_valid = (c < DEPTH);
      bus.s_data  = 8'(c);
      @(negedge clk);
      if (bus.m_valid === 1'b1 && got < DEPTH) begin
        checks++;
        if (bus.m_data !== model[got]) begin
          errors++;
          $display("[TB] FAIL restart_data addr %0d: got %0h expected %0h", got, bus.m_data, model[got]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (got != DEPTH) begin
      errors++;
      $display("[TB] FAIL restart_count: got %0d expected %0d", got, DEPTH);
    end
  endtask

  task automatic test_reset_midstream();
    int got = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_precondition: got m_valid=%b expected 1", bus.m_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.m_valid, bus.s_ready, bus.loaded, bus.cfg_ready} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midrst_async: got %b expected 0000",
               {bus.m_valid, bus.s_ready, bus.loaded, bus.cfg_ready});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 2'($urandom);
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'($urandom);
      bus.m_ready   = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.cfg_ready, bus.s_ready, bus.m_valid, bus.loaded} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL midrst_ignore cycle %0d: got %b expected 0000", i,
                 {bus.cfg_ready, bus.s_ready, bus.m_valid, bus.loaded});
      end
      @(posedge clk); #1;
    end
    drive_idle();
    test_load();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.s_valid = (i < 16);
      bus.s_data  = 8'($urandom);
      @(negedge clk);
      if (bus.m_valid === 1'b1) got++;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (got != 16) begin
      errors++;
      $display("[TB] FAIL midrst_reload_count: got %0d expected 16", got);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_load();
    test_back_to_back();
    test_backpressure();
    test_drain_reload();
    test_restart();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
